n4_c2_serial_negator: RTL

N4_C2_SERIAL_NEGATOR -- requirements
Module: n4_c2_serial_negator

---
 rtl/n4_c2_serial_negator_pkg.sv | 13 +
 rtl/n4_shift_register.sv | 38 +++
 rtl/n4_c2_serial_negator.sv | 114 +++++++++++
 3 files changed

// File: rtl/n4_c2_serial_negator_pkg.sv
// Shared constants and state encoding for the serial two's-complement negator.
package n4_c2_serial_negator_pkg;

  localparam int N_BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_COPY   = 2'b01,
    ST_INVERT = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/n4_shift_register.sv
// Right shift register: serial input enters at the MSB, with load-enable and
// synchronous clear. Reset has priority over clear, clear over shift.
module n4_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next contents: clear, shift right with sin at the top, or hold.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = {sin, q_q[WIDTH-1:1]};
    end
  end

  // Contents register with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/n4_c2_serial_negator.sv
// Serial two's-complement negator. Operand bits arrive LSB first; bits are
// copied up to and including the first 1, and inverted afterwards. The
// result accumulates in a right shift register and is presented with a
// valid/ready handshake once all operand bits have been taken.
module n4_c2_serial_negator
  import n4_c2_serial_negator_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              x_bit,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [N_BITS-1:0] z3_z0,
  output logic              ow,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             x3_q;
  logic             x3_d;

  logic             sr_clr;
  logic             sr_en;
  logic             sr_sin;
  logic [N_BITS-1:0] sr_q;

  // Next-state, bit counter, sign capture and shift-register controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x3_d    = x3_q;
    sr_clr  = 1'b0;
    sr_en   = 1'b0;
    sr_sin  = x_bit;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COPY;
          cnt_d   = '0;
          x3_d    = 1'b0;
          sr_clr  = 1'b1;
        end
      end

      ST_COPY, ST_INVERT: begin
        if (bit_valid) begin
          sr_en  = 1'b1;
          // The bit that carries the first 1 is still copied; inversion
          // starts with the following accepted bit.
          sr_sin = (state_q == ST_INVERT) ? ~x_bit : x_bit;
          if (state_q == ST_COPY && x_bit) begin
            state_d = ST_INVERT;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_BITS - 1)) begin
            x3_d    = x_bit;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and sign registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x3_q    <= x3_d;
    end
  end

  n4_shift_register #(
    .WIDTH(N_BITS)
  ) u_shift (
    .clk  (clock),
    .srst (reset),
    .clr  (sr_clr),
    .en   (sr_en),
    .sin  (sr_sin),
    .q    (sr_q)
  );

  // Outputs come only from registers and the state decode. Overflow is only
  // possible for the most negative operand: its sign and the result sign
  // are both 1.
  assign bit_ready = (state_q == ST_COPY) || (state_q == ST_INVERT);
  assign out_valid = (state_q == ST_DONE);
  assign z3_z0     = sr_q;
  assign ow        = x3_q & sr_q[N_BITS-1];

endmodule
